// File: rtl/bcp_unit_prop_if.sv
// Bus between the decision logic (master) and the BCP engine (slave):
// clause loading, propagation start, implication stream and final assignment.
interface bcp_unit_prop_if #(
  parameter int var_num    = 8,
  parameter int clause_num = 16
);
  localparam int IW = $clog2(clause_num);
  localparam int VW = $clog2(var_num);

  logic               clear;
  logic               load_valid;
  logic [var_num-1:0] load_mask;
  logic [var_num-1:0] load_type;
  logic               load_ready;
  logic               start;
  logic [var_num-1:0] init_assign;
  logic [var_num-1:0] init_assigned;
  logic               busy;
  logic               done;
  logic               conflict;
  logic [IW-1:0]      conflict_idx;
  logic               imp_valid;
  logic [VW-1:0]      imp_var;
  logic               imp_val;
  logic [var_num-1:0] assign_out;
  logic [var_num-1:0] assigned_out;
  logic [IW:0]        clause_count;

  modport master (
    output clear, load_valid, load_mask, load_type, start, init_assign, init_assigned,
    input  load_ready, busy, done, conflict, conflict_idx, imp_valid, imp_var, imp_val,
           assign_out, assigned_out, clause_count
  );

  modport slave (
    input  clear, load_valid, load_mask, load_type, start, init_assign, init_assigned,
    output load_ready, busy, done, conflict, conflict_idx, imp_valid, imp_var, imp_val,
           assign_out, assigned_out, clause_count
  );
endinterface

// File: rtl/bcp_unit_prop.sv
// Sequential unit-propagation engine: scans the stored clauses one per cycle,
// assigns implied literals and repeats passes until stable or a clause is falsified.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepts clause loads / clear; waits for start
// SCAN  | evaluates clause idx this cycle; restarts the pass on change
// DONE  | one cycle; raises the registered done pulse, returns to IDLE
module bcp_unit_prop #(
  parameter int var_num    = 8,
  parameter int clause_num = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bcp_unit_prop_if.slave bus
);
  localparam int IW = $clog2(clause_num);
  localparam int VW = $clog2(var_num);

  localparam logic [IW-1:0]      IDX_ONE = IW'(1);
  localparam logic [IW:0]        CNT_ONE = (IW+1)'(1);
  localparam logic [IW:0]        CNT_MAX = (IW+1)'(clause_num);
  localparam logic [var_num-1:0] VEC_ONE = var_num'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state;
  logic [IW:0]        count;
  logic [IW-1:0]      idx;
  logic               changed;
  logic [var_num-1:0] a_q;
  logic [var_num-1:0] v_q;
  logic               busy_q;
  logic               done_q;
  logic               conflict_q;
  logic [IW-1:0]      conflict_idx_q;
  logic               imp_valid_q;
  logic [VW-1:0]      imp_var_q;
  logic               imp_val_q;

  logic [var_num-1:0] mask_mem [clause_num];
  logic [var_num-1:0] type_mem [clause_num];

  logic [var_num-1:0] cur_m;
  logic [var_num-1:0] cur_t;
  logic [var_num-1:0] free;
  logic               sat;
  logic               free_none;
  logic               free_one;
  logic [VW-1:0]      free_k;
  logic               last;
  logic               load_ready;
  logic               accept_load;

  assign load_ready  = (state == S_IDLE) && (count < CNT_MAX);
  assign accept_load = load_ready && bus.load_valid && !bus.clear;

  // Clause evaluation against the live assignment; single-free test uses x & (x-1).
  always_comb begin
    cur_m     = mask_mem[idx];
    cur_t     = type_mem[idx];
    sat       = |(cur_m & v_q & ~(a_q ^ cur_t));
    free      = cur_m & ~v_q;
    free_none = (free == '0);
    free_one  = !free_none && ((free & (free - VEC_ONE)) == '0);
    free_k    = '0;
    for (int i = var_num - 1; i >= 0; i--) begin
      if (free[i]) free_k = VW'(i);
    end
    last = ({1'b0, idx} == (count - CNT_ONE));
  end

  always_ff @(posedge clk) begin
    if (accept_load) begin
      mask_mem[count[IW-1:0]] <= bus.load_mask;
      type_mem[count[IW-1:0]] <= bus.load_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      count          <= '0;
      idx            <= '0;
      changed        <= 1'b0;
      a_q            <= '0;
      v_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      imp_valid_q    <= 1'b0;
      imp_var_q      <= '0;
      imp_val_q      <= 1'b0;
    end else begin
      imp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.clear) begin
            count <= '0;
          end else if (accept_load) begin
            count <= count + CNT_ONE;
          end
          if (bus.start) begin
            a_q            <= bus.init_assign & bus.init_assigned;
            v_q            <= bus.init_assigned;
            idx            <= '0;
            changed        <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
            if (count != '0) begin
              state  <= S_SCAN;
              busy_q <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_SCAN: begin
          if (!sat && free_none) begin
            conflict_q     <= 1'b1;
            conflict_idx_q <= idx;
            state          <= S_DONE;
            busy_q         <= 1'b0;
          end else begin
            if (!sat && free_one) begin
              a_q[free_k] <= cur_t[free_k];
              v_q[free_k] <= 1'b1;
              imp_valid_q <= 1'b1;
              imp_var_q   <= free_k;
              imp_val_q   <= cur_t[free_k];
            end
            // The implication on the last clause counts toward restarting the pass.
            if (last) begin
              if (changed || (!sat && free_one)) begin
                idx     <= '0;
                changed <= 1'b0;
              end else begin
                state  <= S_DONE;
                busy_q <= 1'b0;
              end
            end else begin
              idx <= idx + IDX_ONE;
              if (!sat && free_one) changed <= 1'b1;
            end
          end
        end

        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_idx = conflict_idx_q;
  assign bus.imp_valid    = imp_valid_q;
  assign bus.imp_var      = imp_var_q;
  assign bus.imp_val      = imp_val_q;
  assign bus.assign_out   = a_q;
  assign bus.assigned_out = v_q;
  assign bus.clause_count = count;
endmodule

// File: tb/tb_bcp_unit_prop.sv
// Bench for bcp_unit_prop: directed scenarios plus random clause sets checked
// against a pass-by-pass propagation model.
module tb_bcp_unit_prop;
  localparam int VN = 8;
  localparam int CN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcp_unit_prop_if #(.var_num(VN), .clause_num(CN)) bus();
  bcp_unit_prop #(.var_num(VN), .clause_num(CN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {int cyc; int vr; int val;} imp_t;
  imp_t exp_imp[$];
  imp_t obs_imp[$];
  logic [7:0] m_mask[$];
  logic [7:0] m_type[$];
  int exp_done, exp_busy, exp_conf, exp_cidx;
  logic [7:0] exp_a, exp_v;
  int obs_done, obs_busy;

  task automatic load_clause(input logic [7:0] m, input logic [7:0] t);
    bus.load_valid = 1'b1;
    bus.load_mask  = m;
    bus.load_type  = t;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    if (m_mask.size() < CN) begin
      m_mask.push_back(m);
      m_type.push_back(t);
    end
  endtask

  task automatic clear_store();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    m_mask.delete();
    m_type.delete();
  endtask

  // Pulses start, then records implications/busy cycles until done or the budget runs out.
  // Cycle k counts edges after the edge that samples start.
  task automatic run_prop(input logic [7:0] ia, input logic [7:0] iv);
    bus.init_assign   = ia;
    bus.init_assigned = iv;
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    obs_imp.delete();
    obs_done = -1;
    obs_busy = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bus.imp_valid) obs_imp.push_back('{k, int'(bus.imp_var), int'(bus.imp_val)});
      if (bus.busy) obs_busy++;
      if (bus.done) begin
        obs_done = k;
        break;
      end
    end
  endtask

  // Reference: repeated passes over the clause list until a pass changes nothing.
  task automatic model_run(input logic [7:0] ia, input logic [7:0] iv);
    logic [7:0] a, v;
    int s, nfree, fb;
    bit sat, chg;
    a = ia & iv;
    v = iv;
    s = 0;
    exp_imp.delete();
    exp_conf = 0;
    exp_cidx = 0;
    for (int p = 0; p < VN + 2 && m_mask.size() > 0; p++) begin
      chg = 0;
      for (int c = 0; c < m_mask.size(); c++) begin
        s++;
        sat = 0;
        nfree = 0;
        fb = 0;
        for (int b = 0; b < VN; b++) begin
          if (m_mask[c][b] && v[b] && (a[b] == m_type[c][b])) sat = 1;
          if (m_mask[c][b] && !v[b]) begin
            nfree++;
            fb = b;
          end
        end
        if (!sat && nfree == 0) begin
          exp_conf = 1;
          exp_cidx = c;
          break;
        end
        if (!sat && nfree == 1) begin
          a[fb] = m_type[c][fb];
          v[fb] = 1'b1;
          chg = 1;
          exp_imp.push_back('{s, fb, int'(m_type[c][fb])});
        end
      end
      if (exp_conf != 0 || !chg) break;
    end
    exp_busy = s;
    exp_done = s + 1;
    exp_a = a;
    exp_v = v;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.conflict, bus.conflict_idx, bus.imp_valid, bus.imp_var,
         bus.imp_val, bus.assign_out, bus.assigned_out, bus.clause_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_zero busy=%b done=%b conflict=%b cidx=%0d imp=%b assign=%h assigned=%h count=%0d",
               bus.busy, bus.done, bus.conflict, bus.conflict_idx, bus.imp_valid,
               bus.assign_out, bus.assigned_out, bus.clause_count);
    end
    checks++;
    if (bus.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unit();
    clear_store();
    load_clause(8'h03, 8'h03);
    run_prop(8'h00, 8'h01);
    checks++;
    if (obs_done !== 3) begin
      failures++;
      $display("FAIL unit_done_cycle got=%0d exp=3", obs_done);
    end
    checks++;
    if (obs_imp.size() != 1) begin
      failures++;
      $display("FAIL unit_imp_count got=%0d exp=1", obs_imp.size());
    end else begin
      checks++;
      if (obs_imp[0].cyc != 1 || obs_imp[0].vr != 1 || obs_imp[0].val != 1) begin
        failures++;
        $display("FAIL unit_imp got=cyc%0d/x%0d=%0d exp=cyc1/x1=1",
                 obs_imp[0].cyc, obs_imp[0].vr, obs_imp[0].val);
      end
    end
    checks++;
    if (bus.assign_out !== 8'h02 || bus.assigned_out !== 8'h03 || bus.conflict !== 1'b0) begin
      failures++;
      $display("FAIL unit_final got=assign %h assigned %h conflict %b exp=02 03 0",
               bus.assign_out, bus.assigned_out, bus.conflict);
    end
  endtask

  task automatic test_chain();
    clear_store();
    load_clause(8'h03, 8'h02);
    load_clause(8'h06, 8'h04);
    run_prop(8'h01, 8'h01);
    checks++;
    if (obs_done !== 5 || obs_busy !== 4) begin
      failures++;
      $display("FAIL chain_timing got=done %0d busy %0d exp=5 4", obs_done, obs_busy);
    end
    checks++;
    if (obs_imp.size() != 2) begin
      failures++;
      $display("FAIL chain_imp_count got=%0d exp=2", obs_imp.size());
    end else begin
      checks++;
      if (obs_imp[0].cyc != 1 || obs_imp[0].vr != 1 || obs_imp[1].cyc != 2 || obs_imp[1].vr != 2) begin
        failures++;
        $display("FAIL chain_imp_order got=cyc%0d/x%0d cyc%0d/x%0d exp=cyc1/x1 cyc2/x2",
                 obs_imp[0].cyc, obs_imp[0].vr, obs_imp[1].cyc, obs_imp[1].vr);
      end
    end
    checks++;
    if (bus.assign_out !== 8'h07 || bus.assigned_out !== 8'h07) begin
      failures++;
      $display("FAIL chain_final got=assign %h assigned %h exp=07 07", bus.assign_out, bus.assigned_out);
    end
  endtask

  task automatic test_conflict();
    clear_store();
    load_clause(8'hAA, 8'hAA);
    run_prop(8'h55, 8'hFF);
    checks++;
    if (obs_done !== 2 || obs_imp.size() != 0) begin
      failures++;
      $display("FAIL conflict_timing got=done %0d imps %0d exp=2 0", obs_done, obs_imp.size());
    end
    checks++;
    if (bus.conflict !== 1'b1 || bus.conflict_idx !== 4'd0) begin
      failures++;
      $display("FAIL conflict_flag got=%b idx %0d exp=1 0", bus.conflict, bus.conflict_idx);
    end
    // Restart on the same store with all variables free: conflict must clear.
    run_prop(8'hFF, 8'h00);
    checks++;
    if (obs_done !== 2 || bus.conflict !== 1'b0 || bus.assigned_out !== 8'h00) begin
      failures++;
      $display("FAIL back_to_back got=done %0d conflict %b assigned %h exp=2 0 00",
               obs_done, bus.conflict, bus.assigned_out);
    end
  endtask

  task automatic test_full_clear();
    clear_store();
    for (int i = 0; i < CN; i++) load_clause(8'($urandom), 8'($urandom));
    checks++;
    if (bus.clause_count !== 5'd16 || bus.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got=count %0d ready %b exp=16 0", bus.clause_count, bus.load_ready);
    end
    load_clause(8'h01, 8'h01);
    checks++;
    if (bus.clause_count !== 5'd16) begin
      failures++;
      $display("FAIL overflow_drop got=%0d exp=16", bus.clause_count);
    end
    clear_store();
    checks++;
    if (bus.clause_count !== 5'd0 || bus.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_state got=count %0d ready %b exp=0 1", bus.clause_count, bus.load_ready);
    end
    run_prop(8'($urandom), 8'($urandom));
    checks++;
    if (obs_done !== 1 || obs_busy !== 0 || bus.conflict !== 1'b0) begin
      failures++;
      $display("FAIL empty_start got=done %0d busy %0d conflict %b exp=1 0 0",
               obs_done, obs_busy, bus.conflict);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] ia, iv;
    for (int it = 0; it < 40; it++) begin
      clear_store();
      n = $urandom_range(1, CN);
      for (int c = 0; c < n; c++) load_clause(8'($urandom & $urandom), 8'($urandom));
      ia = 8'($urandom);
      iv = 8'($urandom & $urandom);
      model_run(ia, iv);
      run_prop(ia, iv);
      checks++;
      if (obs_done !== exp_done || obs_busy !== exp_busy) begin
        failures++;
        $display("FAIL rand%0d_timing got=done %0d busy %0d exp=done %0d busy %0d",
                 it, obs_done, obs_busy, exp_done, exp_busy);
      end
      checks++;
      if (obs_imp.size() != exp_imp.size()) begin
        failures++;
        $display("FAIL rand%0d_imp_count got=%0d exp=%0d", it, obs_imp.size(), exp_imp.size());
      end else begin
        for (int j = 0; j < exp_imp.size(); j++) begin
          checks++;
          if (obs_imp[j] != exp_imp[j]) begin
            failures++;
            $display("FAIL rand%0d_imp%0d got=cyc%0d/x%0d=%0d exp=cyc%0d/x%0d=%0d", it, j,
                     obs_imp[j].cyc, obs_imp[j].vr, obs_imp[j].val,
                     exp_imp[j].cyc, exp_imp[j].vr, exp_imp[j].val);
          end
        end
      end
      checks++;
      if (int'(bus.conflict) != exp_conf || int'(bus.conflict_idx) != exp_cidx) begin
        failures++;
        $display("FAIL rand%0d_conflict got=%b idx %0d exp=%0d idx %0d",
                 it, bus.conflict, bus.conflict_idx, exp_conf, exp_cidx);
      end
      checks++;
      if (bus.assign_out !== exp_a || bus.assigned_out !== exp_v) begin
        failures++;
        $display("FAIL rand%0d_assign got=%h/%h exp=%h/%h",
                 it, bus.assign_out, bus.assigned_out, exp_a, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    clear_store();
    load_clause(8'h03, 8'h02);
    load_clause(8'h06, 8'h04);
    bus.init_assign   = 8'h01;
    bus.init_assigned = 8'h01;
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.imp_valid !== 1'b1) begin
      failures++;
      $display("FAIL midscan_pre got=busy %b imp %b exp=1 1", bus.busy, bus.imp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.conflict, bus.conflict_idx, bus.imp_valid, bus.imp_var,
         bus.imp_val, bus.assign_out, bus.assigned_out, bus.clause_count} !== '0
        || bus.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL midscan_async got=busy %b imp %b assign %h assigned %h count %0d ready %b exp=zeros ready 1",
               bus.busy, bus.imp_valid, bus.assign_out, bus.assigned_out, bus.clause_count, bus.load_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_mask.delete();
    m_type.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.clause_count !== 5'd0 || bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL midscan_release got=count %0d busy %b ready %b exp=0 0 1",
               bus.clause_count, bus.busy, bus.load_ready);
    end
  endtask

  initial begin
    bus.clear         = 1'b0;
    bus.load_valid    = 1'b0;
    bus.load_mask     = '0;
    bus.load_type     = '0;
    bus.start         = 1'b0;
    bus.init_assign   = '0;
    bus.init_assigned = '0;
    test_reset();
    test_unit();
    test_chain();
    test_conflict();
    test_full_clear();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcp_unit_prop.md
# bcp_unit_prop

Sequential Boolean-constraint-propagation engine for the hardware BCP path. It stores a small clause database and takes a partial variable assignment from the decision logic. It then scans the clauses one per cycle, finds unit clauses and assigns their implied literals, and repeats until nothing changes or a clause is falsified. Clause encoding matches the partial-satisfaction checker: a clause is a (mask, type) pair over `var_num` variables, where mask bit i set means variable i is in the clause, and type bit i gives its polarity (1 = positive literal).

## Interface
- `var_num`, default 8: number of variables, i.e. the width of every assignment, mask and type vector.
- `clause_num`, default 16: clause storage depth.
- `IW`: index width, `$clog2(clause_num)`.
- `VW`: variable-index width, `$clog2(var_num)`.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: empties the clause store; honoured in IDLE only.
- `load_valid`  in  1: clause write request.
- `load_mask`  in  var_num: clause membership mask.
- `load_type`  in  var_num: clause literal polarities.
- `load_ready`  out  1: clause write accepted this cycle.
- `start`  in  1: begin propagation; honoured in IDLE only.
- `init_assign`  in  var_num: initial variable values.
- `init_assigned`  in  var_num: initial assigned-variable mask.
- `busy`  out  1: engine is scanning.
- `done`  out  1: one-cycle completion pulse.
- `conflict`  out  1: a clause was falsified.
- `conflict_idx`  out  IW: index of the falsified clause.
- `imp_valid`  out  1: an implication was made this cycle.
- `imp_var`  out  VW: variable index of the implication.
- `imp_val`  out  1: value of the implied variable.
- `assign_out`  out  var_num: current variable values.
- `assigned_out`  out  var_num: current assigned-variable mask.
- `clause_count`  out  IW+1: number of clauses stored.

## Operation
FSM states and transitions:
- IDLE -> SCAN on `start` when `clause_count` > 0.
- IDLE -> DONE on `start` when `clause_count` = 0.
- SCAN -> SCAN (idx+1) on the next clause of the current pass.
- SCAN -> SCAN (idx=0) at the end of a pass when the changed flag is set and there is no conflict.
- SCAN -> DONE on a conflict, or at the end of a pass with the changed flag clear.
- DONE -> IDLE unconditionally.

Loading:
- `load_ready` = (state==IDLE) && (`clause_count` < `clause_num`).
- When `load_valid` && `load_ready`: the clause is written to slot `clause_count`, and `clause_count` increments.
- A load while full or while not in IDLE is dropped silently.
- `clear` in IDLE sets `clause_count` to 0. If `clear` and `load_valid` occur in the same cycle, `clear` wins.

Start:
- Latch A = `init_assign` & `init_assigned` and V = `init_assigned`.
- Set idx=0, changed=0, conflict=0.

Per SCAN cycle, on clause idx (M, T):
- sat = |(M & V & ~(A ^ T))
- free = M & ~V
- If sat: no action.
- Else if popcount(free)==0: set `conflict`=1 and `conflict_idx`=idx, then go to DONE. A clause with M=0 is therefore a conflict.
- Else if popcount(free)==1, with k the set bit of free:
  - set V[k]=1 and A[k]=T[k], and set changed=1;
  - pulse `imp_valid` with `imp_var`=k and `imp_val`=T[k].
  - The updated A and V are visible to clause idx+1 in the same pass.
- Else (two or more free literals): no action.

End of pass (idx==`clause_count`-1):
- If changed and no conflict: clear changed, set idx=0 and stay in SCAN.
- Otherwise: go to DONE.

Termination: each pass that does not terminate assigns at least one variable, so there are at most `var_num`+1 passes.

## Timing
- Reset values: all outputs are 0 except `load_ready`=1. The clause store count is 0 and the state is IDLE. Reset is asynchronous, so asserting it mid-scan aborts immediately.
- `start` sampled at edge t → the first SCAN cycle is t+1 and handles one clause per cycle.
- Completion with C clauses and P passes: `done`=1 for the single cycle t+P·C+1. `busy`=1 exactly during the SCAN cycles.
- An early conflict at clause j of pass p: `done` lands at t+(p-1)·C+j+2.
- `imp_valid` is registered, one cycle per implication, and aligned with the `assign_out` update.
- `assign_out`, `assigned_out`, `conflict` and `conflict_idx` hold their values after DONE until the next accepted `start`.
- `start` during SCAN or DONE is ignored.

## Test plan
1. Reset → all outputs 0, `load_ready`=1, `clause_count`=0.
2. Unit implication:
   - Stimulus: load mask 00000011, type 00000011; start with `init_assigned`=00000001, `init_assign`=00000000.
   - Response: `imp_valid` at t+1 with `imp_var`=1, `imp_val`=1; `done` at t+3; `assign_out`=00000010, `assigned_out`=00000011, `conflict`=0.
3. Chain within one pass:
   - Stimulus: load clause 0 (mask 00000011, type 00000010) and clause 1 (mask 00000110, type 00000100); start with `init_assigned`=00000001, `init_assign`=00000001.
   - Response: implications of x1 at t+1 and x2 at t+2; `done` at t+5; `assign_out`=`assigned_out`=00000111.
4. Conflict:
   - Stimulus: load mask 10101010, type 10101010; start with `init_assigned`=11111111, `init_assign`=01010101.
   - Response: `conflict`=1, `conflict_idx`=0, `done` at t+2, no `imp_valid`.
5. Full and clear:
   - Load 16 clauses → `load_ready`=0 and `clause_count`=16; a 17th load is dropped.
   - `clear` → `clause_count`=0.
   - `start` with no clauses → `done` at t+1, `conflict`=0.
6. Reset mid-scan: drop `rst_n` during SCAN of the test 3 setup → all outputs 0 asynchronously, `clause_count`=0, state IDLE after release.
